// File: rtl/hdr_word_tracker.sv
// rtl/hdr_word_tracker.sv - passive header-word tracker: module-header count, per-word strobes, VLAN/short/EOP flags
module hdr_word_tracker #(
  parameter int              DATA_WIDTH    = 64,
  parameter int              CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int              NUM_HDR_WORDS = 5,
  parameter int              ETYPE_WORD    = 1,
  parameter int              ETYPE_LSB     = 16,
  parameter logic [15:0]     VLAN_TPID     = 16'h8100,
  parameter int              MOD_CNT_WIDTH = 4,
  localparam int             IDX_WIDTH     = (NUM_HDR_WORDS > 1) ? $clog2(NUM_HDR_WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [CTRL_WIDTH-1:0]    in_ctrl,
  input  logic                     in_wr,
  output logic [NUM_HDR_WORDS-1:0] word_strobe,
  output logic [IDX_WIDTH-1:0]     word_idx,
  output logic                     in_hdr,
  output logic                     vlan_present,
  output logic [MOD_CNT_WIDTH-1:0] mod_hdr_cnt,
  output logic                     short_pkt,
  output logic                     pkt_done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_HDR_WORDS - 1);
  localparam logic [IDX_WIDTH-1:0] ETYPE_IDX = IDX_WIDTH'(ETYPE_WORD);

  typedef enum logic [1:0] {
    SKIP_MODULE_HDRS,
    HDR,
    WAIT_EOP
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_WIDTH-1:0]       word_idx_q, word_idx_d;
  logic                       vlan_q, vlan_d;
  logic [MOD_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                       clr_pend_q, clr_pend_d;
  logic                       short_q, short_d;
  logic                       done_q, done_d;
  logic [NUM_HDR_WORDS-1:0]   strobe_c;
  logic                       ctrl_nz;
  logic                       etype_match;
  logic                       unused_data;

  assign ctrl_nz     = |in_ctrl;
  assign etype_match = (in_data[ETYPE_LSB +: 16] == VLAN_TPID);
  assign unused_data = ^in_data;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    vlan_d     = vlan_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q;
    short_d    = 1'b0;
    done_d     = 1'b0;
    strobe_c   = '0;
    if (in_wr) begin
      case (state_q)
        SKIP_MODULE_HDRS: begin
          if (ctrl_nz) begin
            // the count restarts with the first module header of the next packet
            clr_pend_d = 1'b0;
            if (clr_pend_q)
              cnt_d = MOD_CNT_WIDTH'(1);
            else if (!(&cnt_q))
              cnt_d = cnt_q + MOD_CNT_WIDTH'(1);
          end else begin
            strobe_c   = NUM_HDR_WORDS'(1);
            word_idx_d = IDX_WIDTH'(1);
            vlan_d     = (ETYPE_WORD == 0) ? etype_match : 1'b0;
            state_d    = HDR;
          end
        end
        HDR: begin
          strobe_c   = NUM_HDR_WORDS'(1) << word_idx_q;
          word_idx_d = word_idx_q + IDX_WIDTH'(1);
          if (word_idx_q == ETYPE_IDX)
            vlan_d = etype_match;
          if (ctrl_nz) begin
            done_d     = 1'b1;
            short_d    = (word_idx_q < LAST_IDX);
            clr_pend_d = 1'b1;
            word_idx_d = '0;
            state_d    = SKIP_MODULE_HDRS;
          end else if (word_idx_q == LAST_IDX) begin
            word_idx_d = '0;
            state_d    = WAIT_EOP;
          end
        end
        WAIT_EOP: begin
          if (ctrl_nz) begin
            done_d     = 1'b1;
            clr_pend_d = 1'b1;
            state_d    = SKIP_MODULE_HDRS;
          end
        end
        default: begin
          state_d    = SKIP_MODULE_HDRS;
          word_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SKIP_MODULE_HDRS;
      word_idx_q <= '0;
      vlan_q     <= 1'b0;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      short_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      vlan_q     <= vlan_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      short_q    <= short_d;
      done_q     <= done_d;
    end
  end

  assign word_strobe  = reset ? '0 : strobe_c;
  assign word_idx     = word_idx_q;
  assign in_hdr       = (state_q == HDR);
  assign vlan_present = vlan_q;
  assign mod_hdr_cnt  = cnt_q;
  assign short_pkt    = short_q;
  assign pkt_done     = done_q;

endmodule

// File: tb/tb_hdr_word_tracker.sv
// tb/tb_hdr_word_tracker.sv - scoreboard bench for hdr_word_tracker (default and 256-bit/3-word variants)
module tb_hdr_word_tracker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [63:0]  in_data0 = '0;
  logic [7:0]   in_ctrl0 = '0;
  logic         in_wr0   = 1'b0;
  logic [4:0]   strobe0;
  logic [2:0]   idx0;
  logic         in_hdr0, vlan0, short0, done0;
  logic [3:0]   cnt0;

  logic [255:0] in_data1 = '0;
  logic [31:0]  in_ctrl1 = '0;
  logic         in_wr1   = 1'b0;
  logic [2:0]   strobe1;
  logic [1:0]   idx1;
  logic         in_hdr1, vlan1, short1, done1;
  logic [3:0]   cnt1;

  hdr_word_tracker u0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_ctrl(in_ctrl0), .in_wr(in_wr0),
    .word_strobe(strobe0), .word_idx(idx0), .in_hdr(in_hdr0), .vlan_present(vlan0),
    .mod_hdr_cnt(cnt0), .short_pkt(short0), .pkt_done(done0)
  );

  hdr_word_tracker #(.DATA_WIDTH(256), .NUM_HDR_WORDS(3), .ETYPE_WORD(0), .ETYPE_LSB(144)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_ctrl(in_ctrl1), .in_wr(in_wr1),
    .word_strobe(strobe1), .word_idx(idx1), .in_hdr(in_hdr1), .vlan_present(vlan1),
    .mod_hdr_cnt(cnt1), .short_pkt(short1), .pkt_done(done1)
  );

  int total = 0;
  int bad   = 0;
  int exp_s0[$];
  int exp_s1[$];
  logic [5:0] exp_p0[$];
  logic [5:0] exp_p1[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // strobe and pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (in_wr0) begin
        if (exp_s0.size() == 0) check("u0_strobe_unexpected", 64'(strobe0), 64'hFFFF);
        else check("u0_strobe", 64'(strobe0), 64'(exp_s0.pop_front()));
      end else check("u0_idle_strobe", 64'(strobe0), 64'h0);
      if (done0) begin
        if (exp_p0.size() == 0) check("u0_done_unexpected", 64'(done0), 64'h0);
        else check("u0_done_short_vlan_cnt", 64'({short0, vlan0, cnt0}), 64'(exp_p0.pop_front()));
      end else check("u0_short_without_done", 64'(short0), 64'h0);

      if (in_wr1) begin
        if (exp_s1.size() == 0) check("u1_strobe_unexpected", 64'(strobe1), 64'hFFFF);
        else check("u1_strobe", 64'(strobe1), 64'(exp_s1.pop_front()));
      end else check("u1_idle_strobe", 64'(strobe1), 64'h0);
      if (done1) begin
        if (exp_p1.size() == 0) check("u1_done_unexpected", 64'(done1), 64'h0);
        else check("u1_done_short_vlan_cnt", 64'({short1, vlan1, cnt1}), 64'(exp_p1.pop_front()));
      end else check("u1_short_without_done", 64'(short1), 64'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send0(input logic [7:0] c, input logic [63:0] d, input int es);
    in_wr0 = 1'b1; in_ctrl0 = c; in_data0 = d;
    exp_s0.push_back(es);
    @(posedge clk);
    #1;
    in_wr0 = 1'b0; in_ctrl0 = '0; in_data0 = '0;
  endtask

  task automatic send1(input logic [31:0] c, input logic [255:0] d, input int es);
    in_wr1 = 1'b1; in_ctrl1 = c; in_data1 = d;
    exp_s1.push_back(es);
    @(posedge clk);
    #1;
    in_wr1 = 1'b0; in_ctrl1 = '0; in_data1 = '0;
  endtask

  // mods module headers, then nwords packet words (last carries EOP); w1 is header word 1
  task automatic pkt0(input int mods, input int nwords, input int gap, input logic [63:0] w1, input int ecnt);
    for (int m = 0; m < mods; m++) begin
      send0(8'hFF, 64'h0, 0);
      idle(gap);
    end
    for (int i = 0; i < nwords; i++) begin
      logic last;
      last = (i == nwords - 1);
      if (last) exp_p0.push_back({nwords < 5, w1[31:16] == 16'h8100, 4'(ecnt)});
      send0(last ? 8'h80 : 8'h00, (i == 1) ? w1 : 64'(i), (i < 5) ? (1 << i) : 0);
      idle(gap);
    end
  endtask

  localparam logic [63:0] W_VLAN = 64'h0000_0000_8100_0000;
  localparam logic [63:0] W_IPV4 = 64'h0000_0000_0800_0000;

  initial begin
    logic [255:0] d;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_word_idx", 64'(idx0), 64'h0);
    check("rst_in_hdr", 64'(in_hdr0), 64'h0);
    check("rst_vlan", 64'(vlan0), 64'h0);
    check("rst_cnt", 64'(cnt0), 64'h0);
    check("rst_pulses", 64'({short0, done0}), 64'h0);
    check("rst_strobe", 64'(strobe0), 64'h0);

    pkt0(1, 7, 0, 64'h0, 1);
    send0(8'hFF, 64'h0, 0);
    send0(8'h00, 64'h0, 1);
    check("in_hdr_after_word0", 64'(in_hdr0), 64'h1);
    check("idx_after_word0", 64'(idx0), 64'h1);
    send0(8'h80, 64'h0, 2);
    exp_p0.push_back({1'b1, 1'b0, 4'd1});

    pkt0(1, 7, 0, W_VLAN, 1);
    check("vlan_held_after_done", 64'(vlan0), 64'h1);
    pkt0(1, 6, 0, W_IPV4, 1);
    pkt0(2, 3, 0, 64'h0, 2);
    idle(1);
    check("short_pkt_back_to_skip", 64'({in_hdr0, idx0}), 64'h0);
    pkt0(1, 7, 2, 64'h0, 1);
    pkt0(20, 5, 0, 64'h0, 15);

    send0(8'hFF, 64'h0, 0);
    send0(8'h00, 64'h0, 1);
    send0(8'h00, 64'h0, 2);
    reset = 1'b1; in_wr0 = 1'b1; in_data0 = 64'h2;
    @(posedge clk);
    #1;
    reset = 1'b0; in_wr0 = 1'b0; in_data0 = '0;
    check("midrst_state_idx", 64'({in_hdr0, idx0}), 64'h0);
    check("midrst_pulses", 64'({short0, done0}), 64'h0);
    check("midrst_cnt", 64'(cnt0), 64'h0);
    pkt0(1, 6, 0, 64'h0, 1);

    pkt0(1, 6, 0, W_VLAN, 1);
    pkt0(0, 4, 0, W_VLAN, 1);
    pkt0(1, 2, 0, 64'h0, 1);
    idle(3);

    send1(32'hFFFF_FFFF, 256'h0, 0);
    d = '0; d[159:144] = 16'h8100;
    send1(32'h0, d, 1);
    check("u1_vlan_from_word0", 64'(vlan1), 64'h1);
    send1(32'h0, 256'h0, 2);
    send1(32'h0, 256'h0, 4);
    exp_p1.push_back({1'b0, 1'b1, 4'd1});
    send1(32'h80, 256'h0, 0);
    d = '0; d[159:144] = 16'h0800;
    send1(32'h0, d, 1);
    exp_p1.push_back({1'b1, 1'b0, 4'd1});
    send1(32'h80, 256'h0, 2);
    idle(4);

    check("u0_strobes_left", 64'(exp_s0.size()), 64'h0);
    check("u0_pulses_left", 64'(exp_p0.size()), 64'h0);
    check("u1_strobes_left", 64'(exp_s1.size()), 64'h0);
    check("u1_pulses_left", 64'(exp_p1.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
